// File: rtl/code_conv_pkg.sv
// rtl/code_conv_pkg.sv - shared mode constants, BCD limit and FSM state type for the code conversion scheduler
package code_conv_pkg;

  localparam logic [2:0] MODE_B2G   = 3'b000;
  localparam logic [2:0] MODE_G2B   = 3'b001;
  localparam logic [2:0] MODE_B2BCD = 3'b010;
  localparam logic [2:0] MODE_BCD2B = 3'b011;
  localparam logic [2:0] MODE_B2XS3 = 3'b100;
  localparam logic [2:0] MODE_XS32B = 3'b101;

  localparam logic [7:0] BCD_LIMIT = 8'd99;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/code_conv_unit.sv
// rtl/code_conv_unit.sv - combinational 8-bit code converter (gray, BCD, excess-3)
module code_conv_unit
  import code_conv_pkg::*;
(
  input  logic [7:0] op,
  input  logic [2:0] md,
  output logic [7:0] data,
  output logic       err
);

  logic [7:0] gray_dec;
  logic [3:0] tens;
  logic [3:0] ones;

  // Gray decode: each binary bit is the parity of all gray bits at and above it.
  always_comb begin
    gray_dec = 8'd0;
    for (int i = 0; i < 8; i++) begin
      gray_dec[i] = ^(op >> i);
    end
  end

  // Decimal digits of the operand; the tens digit is truncated to a nibble above 99.
  always_comb begin
    tens = 4'(op / 8'd10);
    ones = 4'(op % 8'd10);
  end

  // Mode select; unused modes return zero data flagged as an error.
  always_comb begin
    data = 8'd0;
    err  = 1'b0;
    case (md)
      MODE_B2G:   data = op ^ (op >> 1);
      MODE_G2B:   data = gray_dec;
      MODE_B2BCD: begin
        data = {tens, ones};
        err  = (op > BCD_LIMIT);
      end
      MODE_BCD2B: begin
        data = ({4'd0, op[7:4]} * 8'd10) + {4'd0, op[3:0]};
        err  = (op[7:4] > 4'd9) || (op[3:0] > 4'd9);
      end
      MODE_B2XS3: data = op + 8'd3;
      MODE_XS32B: data = op - 8'd3;
      default: begin
        data = 8'd0;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/code_conv_scheduler.sv
// rtl/code_conv_scheduler.sv - round-robin arbiter sharing one code converter; CODE_CONV_STATS_EN adds done/error counters
module code_conv_scheduler
  import code_conv_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [3*N_REQ-1:0]   req_mode,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [7:0]           resp_data,
  output logic [ID_W-1:0]      resp_id,
  output logic                 resp_err,
  output logic                 busy,
  output logic [15:0]          stat_done,
  output logic [15:0]          stat_err
);

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] cand;
  logic            found;
  logic [7:0]      sel_op;
  logic [2:0]      sel_md;
  logic [7:0]      op_q;
  logic [2:0]      md_q;
  logic [ID_W-1:0] id_q;
  logic [7:0]      conv_data;
  logic            conv_err;
  logic            accept;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  // Operand and mode of the currently granted requester.
  always_comb begin
    sel_op = '0;
    sel_md = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_op = req_data[8*i +: 8];
        sel_md = req_mode[3*i +: 3];
      end
    end
  end

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and the combinational accept strobe to the winner.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (found && !reset) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_nxt        = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the granted operand and move the round-robin pointer to the winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= ID_W'(N_REQ - 1);
      op_q   <= '0;
      md_q   <= '0;
      id_q   <= '0;
    end else if (accept) begin
      rr_ptr <= grant;
      op_q   <= sel_op;
      md_q   <= sel_md;
      id_q   <= grant;
    end
  end

  code_conv_unit u_conv (
    .op   (op_q),
    .md   (md_q),
    .data (conv_data),
    .err  (conv_err)
  );

  // Register the converter result at the end of EXEC; held stable through RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_data <= '0;
      resp_err  <= 1'b0;
      resp_id   <= '0;
    end else if (state == EXEC) begin
      resp_data <= conv_data;
      resp_err  <= conv_err;
      resp_id   <= id_q;
    end
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

`ifdef CODE_CONV_STATS_EN
  logic resp_hs;
  assign resp_hs = resp_valid & resp_ready;

  // Saturating counts of completed responses and of those flagged as errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_done <= '0;
      stat_err  <= '0;
    end else if (resp_hs) begin
      if (stat_done != 16'hFFFF) stat_done <= stat_done + 16'd1;
      if (resp_err && (stat_err != 16'hFFFF)) stat_err <= stat_err + 16'd1;
    end
  end
`else
  assign stat_done = '0;
  assign stat_err  = '0;
`endif

endmodule

// File: tb/tb_code_conv_scheduler.sv
// tb/tb_code_conv_scheduler.sv - self-checking bench for code_conv_scheduler (directed plus randomized)
module tb_code_conv_scheduler;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [7:0]      d [N];
  logic [2:0]      m [N];
  logic [8*N-1:0]  req_data;
  logic [3*N-1:0]  req_mode;
  logic            resp_valid;
  logic            resp_ready;
  logic [7:0]      resp_data;
  logic [1:0]      resp_id;
  logic            resp_err;
  logic            busy;
  logic [15:0]     stat_done;
  logic [15:0]     stat_err;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int rr_model = N - 1;

  assign req_data = {d[3], d[2], d[1], d[0]};
  assign req_mode = {m[3], m[2], m[1], m[0]};

  always #5 clk = ~clk;

  code_conv_scheduler #(.N_REQ(N), .ID_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_mode   (req_mode),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_err   (resp_err),
    .busy       (busy),
    .stat_done  (stat_done),
    .stat_err   (stat_err)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  function automatic void ref_conv(input int op, input int md, output int rd, output int re);
    rd = 0;
    re = 0;
    case (md)
      0: rd = op ^ (op >> 1);
      1: for (int s = op; s != 0; s = s >> 1) rd = rd ^ s;
      2: begin rd = ((op / 10) % 16) * 16 + (op % 10); re = (op > 99) ? 1 : 0; end
      3: begin
        rd = ((op >> 4) * 10 + (op & 15)) % 256;
        re = (((op >> 4) > 9) || ((op & 15) > 9)) ? 1 : 0;
      end
      4: rd = (op + 3) % 256;
      5: rd = (op + 253) % 256;
      default: begin rd = 0; re = 1; end
    endcase
  endfunction

  function automatic int rr_next(input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      if (mask[(rr_model + k) % N]) return (rr_model + k) % N;
    end
    return 0;
  endfunction

  task automatic reset_dut();
    reset = 1'b1;
    req_valid = '0;
    resp_ready = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    rr_model = N - 1;
  endtask

  task automatic do_txn(input int r, input int op, input int md, input int ed, input int ee, input int hold);
    int n;
    int g;
    req_valid = '0;
    req_valid[r] = 1'b1;
    d[r] = 8'(op);
    m[r] = 3'(md);
    resp_ready = (hold == 0);
    #1;
    n = 0;
    while (req_ready == '0 && n < 10) begin cyc(); n++; end
    g = rr_next(req_valid);
    chk("txn_grant", req_ready, 1 << g);
    rr_model = g;
    cyc();
    chk("txn_exec_valid", resp_valid, 0);
    chk("txn_exec_busy", busy, 1);
    req_valid = '1;
    cyc();
    for (int i = 0; i <= hold; i++) begin
      chk("txn_resp_valid", resp_valid, 1);
      chk("txn_resp_data", resp_data, ed);
      chk("txn_resp_id", resp_id, r);
      chk("txn_resp_err", resp_err, ee);
      chk("txn_resp_noready", req_ready, 0);
      if (i == hold) resp_ready = 1'b1;
      cyc();
    end
    chk("txn_after_hs_grant", req_ready, 1 << rr_next(req_valid));
    req_valid = '0;
    #1;
    chk("txn_idle_busy", busy, 0);
  endtask

  int n, g, ed, ee, last, m_age;
  logic m_busy;
  int qd[$];
  int qe[$];
  int qi[$];
  int t_r  [11] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
  int t_op [11] = '{8'h2D, 8'h3B, 8'h3F, 8'h99, 8'hFE, 8'h01, 8'hC8, 8'h3A, 8'h5A, 8'h00, 8'hFF};
  int t_md [11] = '{0, 1, 2, 3, 4, 5, 2, 3, 6, 0, 7};
  int t_d  [11] = '{8'h3B, 8'h2D, 8'h63, 8'h63, 8'h01, 8'hFE, 8'h40, 8'h28, 8'h00, 8'h00, 8'h00};
  int t_e  [11] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1};

  initial begin
    reset = 1'b1;
    req_valid = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin d[i] = '0; m[i] = '0; end
    reset_dut();

    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stat_done", stat_done, 0);
    chk("rst_stat_err", stat_err, 0);

    for (int i = 0; i < 11; i++) do_txn(t_r[i], t_op[i], t_md[i], t_d[i], t_e[i], 0);

    do_txn(1, 8'h2D, 0, 8'h3B, 0, 5);

    reset_dut();
    for (int i = 0; i < N; i++) begin d[i] = 8'($urandom); m[i] = 3'($urandom_range(0, 5)); end
    req_valid = '1;
    resp_ready = 1'b1;
    #1;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (req_ready == '0 && n < 10) begin cyc(); n++; end
      g = rr_next(req_valid);
      chk("fair_grant", req_ready, 1 << g);
      chk("fair_order", g, k % N);
      if (k > 0) chk("fair_gap", cyc_n - last, 3);
      last = cyc_n;
      ref_conv(int'(d[g]), int'(m[g]), ed, ee);
      rr_model = g;
      cyc();
      d[g] = 8'($urandom);
      m[g] = 3'($urandom_range(0, 5));
      cyc();
      chk("fair_resp_valid", resp_valid, 1);
      chk("fair_resp_id", resp_id, g);
      chk("fair_resp_data", resp_data, ed);
      chk("fair_resp_err", resp_err, ee);
      cyc();
    end
    req_valid = '0;

    reset_dut();
    d[2] = 8'h55;
    m[2] = 3'd0;
    req_valid = 4'b0100;
    #1;
    chk("rstx_grant", req_ready, 4'b0100);
    cyc();
    chk("rstx_exec_busy", busy, 1);
    reset = 1'b1;
    req_valid = '0;
    cyc();
    reset = 1'b0;
    rr_model = N - 1;
    for (int i = 0; i < 3; i++) begin
      chk("rstx_no_resp", resp_valid, 0);
      chk("rstx_idle", busy, 0);
      cyc();
    end
    req_valid = '1;
    #1;
    chk("rstx_first_grant", req_ready, 1 << rr_next(req_valid));
    chk("rstx_grant0", req_ready, 4'b0001);
    req_valid = '0;
    #1;

    reset_dut();
    m_busy = 1'b0;
    m_age = 0;
    for (int c = 0; c < 400; c++) begin
      req_valid = (c >= 385) ? 4'b0000 : 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin d[i] = 8'($urandom); m[i] = 3'($urandom_range(0, 7)); end
      resp_ready = (c >= 385) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_busy", busy, m_busy);
      chk("rnd_resp_valid", resp_valid, (m_busy && m_age >= 2));
      if (m_busy) begin
        chk("rnd_no_grant", req_ready, 0);
      end else if (req_valid != '0) begin
        g = rr_next(req_valid);
        chk("rnd_grant", req_ready, 1 << g);
        rr_model = g;
        ref_conv(int'(d[g]), int'(m[g]), ed, ee);
        qd.push_back(ed);
        qe.push_back(ee);
        qi.push_back(g);
        m_busy = 1'b1;
        m_age = 0;
      end else begin
        chk("rnd_idle_ready", req_ready, 0);
      end
      if (m_busy && m_age >= 2 && qd.size() > 0) begin
        chk("rnd_resp_data", resp_data, qd[0]);
        chk("rnd_resp_err", resp_err, qe[0]);
        chk("rnd_resp_id", resp_id, qi[0]);
        if (resp_ready) begin
          void'(qd.pop_front());
          void'(qe.pop_front());
          void'(qi.pop_front());
          m_busy = 1'b0;
        end else begin
          m_age++;
        end
      end else if (m_busy) begin
        m_age++;
      end
      cyc();
    end
    chk("rnd_drained", qd.size(), 0);
    chk("rnd_end_busy", busy, 0);

    reset_dut();
    do_txn(0, 8'h12, 4, 8'h15, 0, 0);
    do_txn(1, 8'h3B, 1, 8'h2D, 0, 2);
    do_txn(2, 8'h99, 3, 8'h63, 0, 0);
    do_txn(3, 8'h10, 7, 8'h00, 1, 1);
`ifdef CODE_CONV_STATS_EN
    chk("stat_done", stat_done, 4);
    chk("stat_err", stat_err, 1);
`else
    chk("stat_done_off", stat_done, 0);
    chk("stat_err_off", stat_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
